voice_alloc: RTL and testbench

- Polyphonic voice scheduler between the MIDI interpreter and the NCO bank.
- Accepts note-on/note-off events one at a time over a valid/ready handshake and assigns each to one of VOICES oscillator slots.
- Drives per-voice note number/velocity buses that feed the NCO bank directly.
- Free voices are reused first; when every voice is busy, the oldest active voice is stolen (optional feature).

---
 rtl/voice_alloc_if.sv | 10 +
 rtl/voice_alloc.sv | 100 ++++++++++
 tb/tb_voice_alloc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/voice_alloc_if.sv
// voice_alloc_if: note event valid/ready channel into the voice scheduler
interface voice_alloc_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [6:0] ev_note;
    logic [6:0] ev_vel;
    modport master(output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
    modport slave(input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice scheduler; define VOICE_ALLOC_STEAL_EN to steal the oldest voice when all are busy
module voice_alloc #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    voice_alloc_if.slave        ev,
    output logic [7*VOICES-1:0] note_num,
    output logic [7*VOICES-1:0] note_vel,
    output logic [VOICES-1:0]   active,
    output logic                drop
);
    localparam int IW = $clog2(VOICES);
    localparam logic [IW-1:0] LAST = IW'(VOICES - 1);
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state, state_nx;
    logic [6:0] num_q [VOICES];
    logic [6:0] vel_q [VOICES];
    logic [AGE_W-1:0] age_q [VOICES];
    logic [AGE_W-1:0] o_age;
    logic [IW-1:0] idx, m_idx, f_idx, o_idx, tgt;
    logic [6:0] note_r, vel_r;
    logic on_r, m_hit, f_hit, o_hit, hit, accept;
    assign ev.ev_ready = state == IDLE;
    assign accept = ev.ev_valid & ev.ev_ready & ce;
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else if (ce) state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (ev.ev_valid ? SCAN : IDLE) :
                   state == SCAN ? (idx == LAST ? COMMIT : SCAN) : IDLE;
        hit = m_hit | f_hit | (STEAL & o_hit);
        tgt = m_hit ? m_idx : f_hit ? f_idx : o_idx;
    end
    // trackers keep the lowest qualifying index; strict > makes age ties favour the lower voice
    always_ff @(posedge clk)
        if (!rst_n) begin
            drop   <= 1'b0;
            active <= '0;
            for (int v = 0; v < VOICES; v++) begin
                num_q[v] <= '0;
                vel_q[v] <= '0;
                age_q[v] <= '0;
            end
        end else if (ce) begin
            drop <= 1'b0;
            if (accept) begin
                on_r   <= ev.ev_on && ev.ev_vel != 7'd0;
                note_r <= ev.ev_note;
                vel_r  <= ev.ev_vel;
                idx    <= '0;
                m_hit  <= 1'b0;
                f_hit  <= 1'b0;
                o_hit  <= 1'b0;
            end
            if (state == SCAN) begin
                idx <= idx + IW'(1);
                if (active[idx] && num_q[idx] == note_r && !m_hit) begin
                    m_hit <= 1'b1;
                    m_idx <= idx;
                end
                if (!active[idx] && !f_hit) begin
                    f_hit <= 1'b1;
                    f_idx <= idx;
                end
                if (active[idx] && (!o_hit || age_q[idx] > o_age)) begin
                    o_hit <= 1'b1;
                    o_idx <= idx;
                    o_age <= age_q[idx];
                end
            end
            if (state == COMMIT) begin
                if (on_r && hit) begin
                    for (int v = 0; v < VOICES; v++)
                        if (IW'(v) == tgt) begin
                            num_q[v]  <= note_r;
                            vel_q[v]  <= vel_r;
                            active[v] <= 1'b1;
                            age_q[v]  <= '0;
                        end else if (active[v] && age_q[v] != '1) age_q[v] <= age_q[v] + AGE_W'(1);
                end else if (on_r) drop <= 1'b1;
                else if (m_hit) begin
                    vel_q[m_idx]  <= '0;
                    active[m_idx] <= 1'b0;
                    age_q[m_idx]  <= '0;
                end
            end
        end
    for (genvar g = 0; g < VOICES; g++) begin : g_out
        assign note_num[7*g +: 7] = num_q[g];
        assign note_vel[7*g +: 7] = vel_q[g];
    end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed and random events checked against a rule-level voice model
module tb_voice_alloc;
    localparam int V = 4;
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
    logic [7*V-1:0] note_num, note_vel;
    logic [V-1:0] active;
    logic drop;
    int compared = 0, mismatched = 0;
    logic [6:0] mnum [V];
    logic [6:0] mvel [V];
    int mage [V];
    bit mact [V];
    voice_alloc_if evif();
    voice_alloc #(.VOICES(V), .AGE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .ev(evif),
        .note_num(note_num), .note_vel(note_vel), .active(active), .drop(drop)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] m_num();
        logic [31:0] r = '0;
        for (int i = 0; i < V; i++) r[7*i +: 7] = mnum[i];
        return r;
    endfunction
    function automatic logic [31:0] m_vel();
        logic [31:0] r = '0;
        for (int i = 0; i < V; i++) r[7*i +: 7] = mvel[i];
        return r;
    endfunction
    function automatic logic [31:0] m_act();
        logic [31:0] r = '0;
        for (int i = 0; i < V; i++) r[i] = mact[i];
        return r;
    endfunction
    function automatic void m_clear();
        for (int i = 0; i < V; i++) begin
            mnum[i] = 0; mvel[i] = 0; mage[i] = 0; mact[i] = 0;
        end
    endfunction
    // returns 1 when the note-on is discarded
    function automatic bit model(input bit on, input logic [6:0] n, input logic [6:0] v);
        int m = -1, f = -1, o = -1, t;
        for (int i = 0; i < V; i++) begin
            if (mact[i] && mnum[i] == n && m < 0) m = i;
            if (!mact[i] && f < 0) f = i;
            if (mact[i] && (o < 0 || mage[i] > mage[o])) o = i;
        end
        if (!(on && v != 0)) begin
            if (m >= 0) begin mvel[m] = 0; mact[m] = 0; mage[m] = 0; end
            return 1'b0;
        end
        t = m >= 0 ? m : f >= 0 ? f : STEAL ? o : -1;
        if (t < 0) return 1'b1;
        for (int i = 0; i < V; i++)
            if (i != t && mact[i]) mage[i] = mage[i] < 15 ? mage[i] + 1 : 15;
        mnum[t] = n; mvel[t] = v; mact[t] = 1; mage[t] = 0;
        return 1'b0;
    endfunction
    task automatic check_state(input string tag);
        chk({tag, "_num"}, note_num, m_num());
        chk({tag, "_vel"}, note_vel, m_vel());
        chk({tag, "_act"}, active, m_act());
    endtask
    task automatic do_reset();
        evif.ev_valid = 1'b0;
        rst_n = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
    endtask
    task automatic send(input bit on, input logic [6:0] n, input logic [6:0] v, input bit tog);
        bit d, acc = 1'b0;
        int lat = 0, busy_bad = 0, cyc = 0;
        logic [31:0] act0, num0;
        evif.ev_valid = 1'b1; evif.ev_on = on; evif.ev_note = n; evif.ev_vel = v;
        while (!acc && cyc < 100) begin
            ce = tog ? 1'($urandom_range(1)) : 1'b1;
            acc = evif.ev_ready && ce;
            @(negedge clk);
            cyc++;
        end
        chk("accept", acc, 1);
        act0 = m_act();
        num0 = m_num();
        d = model(on, n, v);
        while (!evif.ev_ready && cyc < 300) begin
            evif.ev_on = 1'($urandom); evif.ev_note = 7'($urandom); evif.ev_vel = 7'($urandom);
            if (active !== act0[V-1:0] || note_num !== num0[7*V-1:0] || drop !== 1'b0) busy_bad++;
            ce = tog ? 1'($urandom_range(1)) : 1'b1;
            if (ce) lat++;
            @(negedge clk);
            cyc++;
        end
        evif.ev_valid = 1'b0;
        chk("latency", lat, V + 1);
        chk("busy_hold", busy_bad, 0);
        chk("drop", drop, d);
        check_state("commit");
        ce = 1'b1;
        @(negedge clk);
        chk("drop_clear", drop, 0);
        chk("ready_idle", evif.ev_ready, 1);
    endtask
    initial begin
        evif.ev_valid = 1'b0; evif.ev_on = 1'b0; evif.ev_note = '0; evif.ev_vel = '0;
        m_clear();
        @(negedge clk);
        do_reset();
        check_state("reset");
        chk("reset_drop", drop, 0);
        chk("reset_ready", evif.ev_ready, 1);
        send(1, 60, 100, 0);
        chk("t1_act", active, 4'b0001);
        chk("t1_v0", {note_num[6:0], note_vel[6:0]}, {7'd60, 7'd100});
        do_reset();
        send(1, 60, 90, 0); send(1, 64, 90, 0); send(1, 67, 90, 0); send(1, 72, 90, 0);
        send(0, 64, 0, 0);
        chk("t2_act", active, 4'b1101);
        chk("t2_v1", {note_num[13:7], note_vel[13:7]}, {7'd64, 7'd0});
        send(1, 76, 80, 0);
        chk("t2_reuse", {note_num[13:7], note_vel[13:7]}, {7'd76, 7'd80});
        do_reset();
        send(1, 60, 100, 0);
        send(1, 60, 50, 0);
        chk("t3_retrig", {active, note_vel[6:0]}, {4'b0001, 7'd50});
        send(1, 60, 0, 0);
        chk("t3_off", active, 4'b0000);
        do_reset();
        send(1, 60, 90, 0); send(1, 64, 90, 0); send(1, 67, 90, 0); send(1, 72, 90, 0);
        send(1, 79, 70, 0);
        if (STEAL) chk("t4_steal", {note_num[6:0], note_vel[6:0]}, {7'd79, 7'd70});
        else chk("t4_keep", {note_num[6:0], note_vel[6:0]}, {7'd60, 7'd90});
        do_reset();
        send(1, 50, 20, 1); send(1, 51, 21, 1); send(0, 50, 5, 1);
        evif.ev_valid = 1'b1; evif.ev_on = 1'b1; evif.ev_note = 7'd70; evif.ev_vel = 7'd33;
        ce = 1'b1;
        @(negedge clk);
        evif.ev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("scan_busy", evif.ev_ready, 0);
        do_reset();
        check_state("midscan_rst");
        chk("midscan_ready", evif.ev_ready, 1);
        for (int k = 0; k < 200; k++)
            send($urandom_range(2) != 0, 7'(60 + $urandom_range(7)),
                 $urandom_range(7) == 0 ? 7'd0 : 7'($urandom_range(1, 127)), 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
